// File: rtl/timer_pkg.sv
// Shared types and default widths for the handshake timer.
package timer_pkg;

  localparam int TIMER_DWIDTH     = 8;
  localparam int TIMER_PRESCALE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: counts 0..div while enabled and emits a one-cycle tick
// on the cycle the counter sits at div (period div+1 enabled cycles).
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;

  logic [PRESCALE_W-1:0] pre_cnt;

  // Tick is only meaningful while counting; it marks the wrap cycle.
  assign tick = en && (pre_cnt == div);

  // Prescaler counter: clear on reset or re-arm, wrap to 0 on tick.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
    end
  end

endmodule

// File: rtl/handshake_timer.sv
// Programmable down-counting timer for the enable/load/flag handshake.
// Counts prescaled ticks from a latched load value and raises flag on expiry,
// either sticky (one-shot) or as a one-cycle pulse with reload (periodic).
module handshake_timer
  import timer_pkg::*;
#(
  parameter int DWIDTH     = TIMER_DWIDTH,
  parameter int PRESCALE_W = TIMER_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [DWIDTH-1:0]     load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  auto_reload,
  output logic                  flag,
  output logic [DWIDTH-1:0]     count,
  output logic                  busy
);

  localparam logic [DWIDTH-1:0] CNT_ONE = 1;

  timer_state_e          state_q;
  timer_state_e          state_d;
  logic [DWIDTH-1:0]     load_val_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  auto_reload_q;
  logic [DWIDTH-1:0]     count_d;
  logic                  flag_d;
  logic                  busy_d;
  logic                  pre_en;
  logic                  tick;
  logic                  run_tick;
  logic                  expire;

  // The prescaler already advances on the ARMED->RUN edge, but only RUN ticks count.
  assign pre_en   = enable && ((state_q == ARMED) || (state_q == RUN));
  assign run_tick = tick && (state_q == RUN);
  // count==0 is treated like count==1 so a zero load expires on its first tick.
  assign expire   = (count <= CNT_ONE);

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (pre_en),
    .div  (prescale_q),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load re-arms from any state and beats tick/enable.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARMED:   if (enable) state_d = RUN;
        RUN:     if (run_tick && expire && !auto_reload_q) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    count_d = count;
    flag_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else begin
      case (state_q)
        IDLE: count_d = '0;
        RUN: begin
          if (run_tick) begin
            if (expire) begin
              count_d = auto_reload_q ? load_val_q : '0;
              flag_d  = 1'b1;
            end else begin
              count_d = count - CNT_ONE;
            end
          end
        end
        DONE: begin
          count_d = '0;
          flag_d  = 1'b1;
        end
        default: count_d = count;
      endcase
    end
    busy_d = (state_d == ARMED) || (state_d == RUN);
  end

  // Output and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      flag          <= 1'b0;
      busy          <= 1'b0;
      load_val_q    <= '0;
      prescale_q    <= '0;
      auto_reload_q <= 1'b0;
    end else begin
      count <= count_d;
      flag  <= flag_d;
      busy  <= busy_d;
      if (load) begin
        load_val_q    <= load_val;
        prescale_q    <= prescale;
        auto_reload_q <= auto_reload;
      end
    end
  end

endmodule
